// File: rtl/stream_demux_1_n.sv
// One-to-N stream demultiplexer with one output register per channel.
// Routing is either addressed by in_sel or round-robin via rr_ptr.

module demux_lane #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          ready,
    input  logic [DW-1:0] din,
    output logic          valid,
    output logic [DW-1:0] data
);
    // A load wins over a drain, so a simultaneous drain and load keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (load)
                valid <= 1'b1;
            else if (ready)
                valid <= 1'b0;
            if (load)
                data <= din;
        end
    end
endmodule

module stream_demux_1_n #(
    parameter int N  = 16,
    parameter int DW = 8,
    parameter int SW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [SW-1:0]   in_sel,
    output logic [N-1:0]    out_valid,
    input  logic [N-1:0]    out_ready,
    output logic [N*DW-1:0] out_data,
    output logic [SW-1:0]   rr_ptr,
    output logic            drop_err
);
    logic [SW-1:0] target;
    logic          in_range;
    logic [N-1:0]  hit;
    logic [N-1:0]  load;
    logic          xfer;

    assign target   = mode ? rr_ptr : in_sel;
    assign in_range = 32'(target) < N;

    // Out-of-range targets are always accepted so they can be discarded.
    assign in_ready = ~in_range | (|(hit & (~out_valid | out_ready)));
    assign xfer     = in_valid & in_ready;
    assign load     = hit & {N{xfer}};

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign hit[k] = (32'(target) == k);

        demux_lane #(.DW(DW)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .ready (out_ready[k]),
            .din   (in_data),
            .valid (out_valid[k]),
            .data  (out_data[k*DW +: DW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            drop_err <= 1'b0;
        end else begin
            drop_err <= xfer & ~in_range;
            if (xfer && mode)
                rr_ptr <= (32'(rr_ptr) == N - 1) ? '0 : rr_ptr + SW'(1);
        end
    end
endmodule
